// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: WDSel sources, load types, PC+8 offset.
// Latency: n/a (constants only).
// Backpressure: n/a.
package wb_pkg;

  // Write-back value source, as carried in M_WDSel
  typedef enum logic [1:0] {
    WD_ALU = 2'd0,
    WD_DM  = 2'd1,
    WD_PC8 = 2'd2,
    WD_MD  = 2'd3
  } wdsel_e;

  // Load extension mode, as carried in M_LoadType; 5-7 behave as LD_W
  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_BU = 3'd1,
    LD_B  = 3'd2,
    LD_HU = 3'd3,
    LD_H  = 3'd4
  } ldtype_e;

  // Link value for jal/jalr: return address skips the delay slot
  localparam int unsigned PC8_OFF = 8;

endpackage

// File: rtl/w_load_ext.sv
// Load data extension: picks byte/half from an aligned word and zero/sign-extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module w_load_ext
  import wb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] data,
  input  logic [1:0]    off,
  input  logic [2:0]    ld_type,
  output logic [DW-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte lane chosen by the low address bits
  always_comb begin
    byte_sel = data[7:0];
    case (off)
      2'd1:    byte_sel = data[15:8];
      2'd2:    byte_sel = data[23:16];
      2'd3:    byte_sel = data[31:24];
      default: byte_sel = data[7:0];
    endcase
  end

  // Halfword lane uses off[1] only; misaligned off[0] is deliberately ignored
  assign half_sel = off[1] ? data[31:16] : data[15:0];

  // Extension by load type; unknown types fall back to the full word
  always_comb begin
    ext = data;
    case (ld_type)
      LD_BU:   ext = {{(DW-8){1'b0}}, byte_sel};
      LD_B:    ext = {{(DW-8){byte_sel[7]}}, byte_sel};
      LD_HU:   ext = {{(DW-16){1'b0}}, half_sel};
      LD_H:    ext = {{(DW-16){half_sel[15]}}, half_sel};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/w_writeback.sv
// W stage: registers M results, selects write-back data, drives RF write port / W forwarding.
// Latency: one register; outputs valid the cycle after M inputs are sampled. Optional trace: WB_TRACE_EN.
// Backpressure: none; the stage always advances (no stall, no flush).
module w_writeback
  import wb_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          M_valid,
  input  logic          M_RegWrite,
  input  logic [RW-1:0] M_A3,
  input  logic [1:0]    M_WDSel,
  input  logic [2:0]    M_LoadType,
  input  logic [DW-1:0] M_PC,
  input  logic [DW-1:0] M_ALUOut,
  input  logic [DW-1:0] M_DMRD,
  input  logic [DW-1:0] M_MDOut,
  output logic          we,
  output logic [RW-1:0] A3,
  output logic [DW-1:0] WD3,
  output logic [DW-1:0] PC,
  output logic [31:0]   retire_cnt
);

  logic          w_valid;
  logic          w_regwrite;
  logic [RW-1:0] w_a3;
  logic [1:0]    w_wdsel;
  logic [2:0]    w_loadtype;
  logic [DW-1:0] w_pc;
  logic [DW-1:0] w_aluout;
  logic [DW-1:0] w_dmrd;
  logic [DW-1:0] w_mdout;
  logic [DW-1:0] load_val;
  logic [DW-1:0] wd_sel;

  // Pipeline register: capture every M-stage field each cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      w_valid    <= 1'b0;
      w_regwrite <= 1'b0;
      w_a3       <= '0;
      w_wdsel    <= '0;
      w_loadtype <= '0;
      w_pc       <= '0;
      w_aluout   <= '0;
      w_dmrd     <= '0;
      w_mdout    <= '0;
    end else begin
      w_valid    <= M_valid;
      w_regwrite <= M_RegWrite;
      w_a3       <= M_A3;
      w_wdsel    <= M_WDSel;
      w_loadtype <= M_LoadType;
      w_pc       <= M_PC;
      w_aluout   <= M_ALUOut;
      w_dmrd     <= M_DMRD;
      w_mdout    <= M_MDOut;
    end
  end

  w_load_ext #(.DW(DW)) u_load_ext (
    .data    (w_dmrd),
    .off     (w_aluout[1:0]),
    .ld_type (w_loadtype),
    .ext     (load_val)
  );

  // Write-back source mux on the registered select
  always_comb begin
    wd_sel = w_aluout;
    case (w_wdsel)
      WD_ALU:  wd_sel = w_aluout;
      WD_DM:   wd_sel = load_val;
      WD_PC8:  wd_sel = w_pc + DW'(PC8_OFF);
      WD_MD:   wd_sel = w_mdout;
      default: wd_sel = w_aluout;
    endcase
  end

  // Bubbles and $0 writes are zeroed so they can never hit a forwarding compare
  assign we  = w_valid & w_regwrite & (w_a3 != '0);
  assign A3  = we ? w_a3 : '0;
  assign WD3 = we ? wd_sel : '0;
  assign PC  = w_pc;

  // Count committed writes; reset clears and also suppresses the write in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt <= '0;
    end else if (we) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

`ifdef WB_TRACE_EN
  // Simulation-only commit trace
  always @(posedge clk) begin
    if (!reset && we) begin
      $display("%0t@%08h: $%0d <= %08h", $time, PC, A3, WD3);
    end
  end
`endif

endmodule

// File: tb/tb_w_writeback.sv
// Randomised and directed self-checking bench for the W stage against a behavioural model.
// Latency: model predicts outputs one edge after stimulus is applied.
// Backpressure: none exercised; the stage always advances.
module tb_w_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        M_valid;
  logic        M_RegWrite;
  logic [4:0]  M_A3;
  logic [1:0]  M_WDSel;
  logic [2:0]  M_LoadType;
  logic [31:0] M_PC;
  logic [31:0] M_ALUOut;
  logic [31:0] M_DMRD;
  logic [31:0] M_MDOut;
  logic        we;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [31:0] PC;
  logic [31:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: what the outputs should be after the most recent edge
  logic        exp_we  = 1'b0;
  logic [4:0]  exp_a3  = '0;
  logic [31:0] exp_wd  = '0;
  logic [31:0] exp_pc  = '0;
  logic [31:0] exp_cnt = '0;

  always #5 clk = ~clk;

  w_writeback #(.DW(32), .RW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .M_valid    (M_valid),
    .M_RegWrite (M_RegWrite),
    .M_A3       (M_A3),
    .M_WDSel    (M_WDSel),
    .M_LoadType (M_LoadType),
    .M_PC       (M_PC),
    .M_ALUOut   (M_ALUOut),
    .M_DMRD     (M_DMRD),
    .M_MDOut    (M_MDOut),
    .we         (we),
    .A3         (A3),
    .WD3        (WD3),
    .PC         (PC),
    .retire_cnt (retire_cnt)
  );

  // Load result from the ISA rules, using shifts and masks on the word
  function automatic logic [31:0] model_load(logic [31:0] d, logic [1:0] off, logic [2:0] lt);
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (8 * off)) & 32'h0000_00FF;
    h = off[1] ? (d >> 16) : (d & 32'h0000_FFFF);
    case (lt)
      3'd1:    return b;
      3'd2:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd3:    return h;
      3'd4:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_wd();
    case (M_WDSel)
      2'd0:    return M_ALUOut;
      2'd1:    return model_load(M_DMRD, M_ALUOut[1:0], M_LoadType);
      2'd2:    return M_PC + 32'd8;
      default: return M_MDOut;
    endcase
  endfunction

  // Advance one clock: update the model from the current inputs, then sample #1 after the edge
  task automatic tick();
    if (!reset && exp_we) exp_cnt = exp_cnt + 32'd1;
    if (reset) begin
      exp_we = 1'b0; exp_a3 = '0; exp_wd = '0; exp_pc = '0; exp_cnt = '0;
    end else begin
      exp_we = M_valid && M_RegWrite && (M_A3 != 5'd0);
      exp_a3 = exp_we ? M_A3 : 5'd0;
      exp_wd = exp_we ? model_wd() : 32'd0;
      exp_pc = M_PC;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(logic v, logic rw, logic [4:0] a3, logic [1:0] sel, logic [2:0] lt,
                       logic [31:0] pc, logic [31:0] alu, logic [31:0] dm, logic [31:0] md);
    M_valid = v; M_RegWrite = rw; M_A3 = a3; M_WDSel = sel; M_LoadType = lt;
    M_PC = pc; M_ALUOut = alu; M_DMRD = dm; M_MDOut = md;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_m(1'b1, 1'b1, 5'd9, 2'd0, 3'd0, 32'h0000_4000, 32'hDEAD_BEEF, 32'h1, 32'h2);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({we, A3, WD3, PC, retire_cnt} !== {1'b0, 5'd0, 32'd0, 32'd0, 32'd0}) begin
        errors++;
        $display("FAIL reset[%0d]: got we=%0b A3=%0d WD3=%08h PC=%08h cnt=%0d, want all zero",
                 i, we, A3, WD3, PC, retire_cnt);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_alu_write();
    set_m(1'b1, 1'b1, 5'd8, 2'd0, 3'd0, 32'h0000_3000, 32'h1234_5678, 32'h0, 32'h0);
    tick();
    checks++;
    if ({we, A3, WD3, PC} !== {1'b1, 5'd8, 32'h1234_5678, 32'h0000_3000}) begin
      errors++;
      $display("FAIL alu_write: got we=%0b A3=%0d WD3=%08h PC=%08h, want 1/8/12345678/00003000",
               we, A3, WD3, PC);
    end
    set_m(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0000_3004, 32'h0, 32'h0, 32'h0);
    tick();
    checks++;
    if (retire_cnt !== 32'd1) begin
      errors++;
      $display("FAIL alu_retire: got cnt=%0d want 1", retire_cnt);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  lt_tab  [6] = '{3'd2, 3'd2, 3'd1, 3'd4, 3'd3, 3'd0};
    logic [1:0]  off_tab [6] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] exp_tab [6] = '{32'hFFFF_FFA5, 32'hFFFF_FFF0, 32'h0000_0080,
                                 32'hFFFF_8070, 32'h0000_F0A5, 32'h8070_F0A5};
    for (int i = 0; i < 6; i++) begin
      set_m(1'b1, 1'b1, 5'd2, 2'd1, lt_tab[i], 32'h0000_3100 + 32'(4 * i),
            {$urandom_range(0, 32'h3FFF_FFFF), off_tab[i]}, 32'h8070_F0A5, 32'h0);
      tick();
      checks++;
      if (WD3 !== exp_tab[i] || we !== 1'b1) begin
        errors++;
        $display("FAIL load_ext[%0d]: got WD3=%08h we=%0b want %08h we=1", i, WD3, we, exp_tab[i]);
      end
    end
  endtask

  task automatic test_jal();
    set_m(1'b1, 1'b1, 5'd31, 2'd2, 3'd0, 32'h0000_3004, 32'h0, 32'h0, 32'h0);
    tick();
    checks++;
    if ({A3, WD3} !== {5'd31, 32'h0000_300C}) begin
      errors++;
      $display("FAIL jal: got A3=%0d WD3=%08h want 31/0000300c", A3, WD3);
    end
    set_m(1'b1, 1'b1, 5'd31, 2'd2, 3'd0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0);
    tick();
    checks++;
    if (WD3 !== 32'h0000_0004) begin
      errors++;
      $display("FAIL jal_wrap: got WD3=%08h want 00000004", WD3);
    end
  endtask

  task automatic test_suppress();
    logic [31:0] cnt0;
    set_m(1'b1, 1'b1, 5'd0, 2'd0, 3'd0, 32'h0000_3200, 32'hAAAA_5555, 32'h0, 32'h0);
    tick();
    cnt0 = retire_cnt;
    checks++;
    if ({we, A3, WD3} !== {1'b0, 5'd0, 32'd0}) begin
      errors++;
      $display("FAIL suppress_r0: got we=%0b A3=%0d WD3=%08h want zeros", we, A3, WD3);
    end
    set_m(1'b0, 1'b1, 5'd7, 2'd3, 3'd0, 32'h0000_3204, 32'h0, 32'h0, 32'h5555_AAAA);
    tick();
    checks++;
    if ({we, A3, WD3, PC} !== {1'b0, 5'd0, 32'd0, 32'h0000_3204}) begin
      errors++;
      $display("FAIL suppress_bubble: got we=%0b A3=%0d WD3=%08h PC=%08h want 0/0/0/00003204",
               we, A3, WD3, PC);
    end
    tick();
    checks++;
    if (retire_cnt !== cnt0) begin
      errors++;
      $display("FAIL suppress_count: got cnt=%0d want %0d", retire_cnt, cnt0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3] = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033};
    for (int i = 0; i < 3; i++) begin
      set_m(1'b1, 1'b1, 5'd5, 2'd3, 3'd0, 32'h0000_3300 + 32'(4 * i), 32'h0, 32'h0, vals[i]);
      tick();
      checks++;
      if ({we, A3, WD3} !== {1'b1, 5'd5, vals[i]}) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got we=%0b A3=%0d WD3=%08h want 1/5/%08h",
                 i, we, A3, WD3, vals[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    set_m(1'b1, 1'b1, 5'd12, 2'd0, 3'd0, 32'h0000_3400, 32'hCAFE_F00D, 32'h0, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({we, A3, WD3, PC, retire_cnt} !== {1'b0, 5'd0, 32'd0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL mid_reset: got we=%0b A3=%0d WD3=%08h PC=%08h cnt=%0d want zeros",
               we, A3, WD3, PC, retire_cnt);
    end
    reset = 1'b0;
    set_m(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    checks++;
    if (retire_cnt !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_count: got cnt=%0d want 0", retire_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 31) == 0);
      set_m(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 31)), 2'($urandom), 3'($urandom),
            $urandom, $urandom, $urandom, $urandom);
      tick();
      checks++;
      if ({we, A3, WD3, PC, retire_cnt} !== {exp_we, exp_a3, exp_wd, exp_pc, exp_cnt}) begin
        errors++;
        $display("FAIL random[%0d]: got we=%0b A3=%0d WD3=%08h PC=%08h cnt=%0d want %0b/%0d/%08h/%08h/%0d",
                 i, we, A3, WD3, PC, retire_cnt, exp_we, exp_a3, exp_wd, exp_pc, exp_cnt);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_m(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    test_reset();
    test_alu_write();
    test_load_ext();
    test_jal();
    test_suppress();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
